// File: rtl/cymo_pkg.sv
// Shared types and widths for the cymometer self-test sweep path.
package cymo_pkg;

   localparam int unsigned DIV_W    = 26;
   localparam int unsigned FREQ_W   = 32;
   localparam int unsigned LOAD_CYC = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      START,
      WAIT,
      REPORT,
      DONE
   } sweep_state_e;

   // One bit wider than the ratio so the compare against the upper limit cannot wrap.
   function automatic logic [DIV_W:0] next_ratio(input logic [DIV_W-1:0] cur,
                                                 input logic [DIV_W-1:0] step);
      return {1'b0, cur} + {1'b0, step};
   endfunction

endpackage

// File: rtl/clk_sweep_ctrl.sv
// Sweeps the test-clock divider ratio, holds the divider in reset on each change,
// waits a settle time, then runs one frequency measurement per ratio.
module clk_sweep_ctrl
   import cymo_pkg::*;
#(
   parameter logic [DIV_W-1:0] DIV_MIN     = 26'd2,
   parameter logic [DIV_W-1:0] DIV_MAX     = 26'd1000,
   parameter logic [DIV_W-1:0] DIV_STEP    = 26'd2,
   parameter logic [15:0]      SETTLE_CYC  = 16'd1024,
   parameter logic [31:0]      TIMEOUT_CYC = 32'd100000000
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic [DIV_W-1:0]  div_n,
   output logic              div_rst_n,
   output logic              meas_start,
   input  logic              meas_done,
   input  logic [FREQ_W-1:0] meas_freq,
   output logic              res_valid,
   output logic [DIV_W-1:0]  res_div,
   output logic [FREQ_W-1:0] res_freq,
   output logic              res_tmo,
   output logic              busy,
   output logic              sweep_done
);

   sweep_state_e   state;
   sweep_state_e   state_nxt;

   logic [15:0]    settle_cnt;
   logic [31:0]    tmo_cnt;
   logic [DIV_W:0] ratio_sum;

   logic           load_last;
   logic           settle_last;
   logic           tmo_last;
   logic           last_step;

   logic           div_rst_n_nxt;
   logic           meas_start_nxt;
   logic           res_valid_nxt;
   logic           sweep_done_nxt;
   logic           busy_nxt;

   assign ratio_sum   = next_ratio(div_n, DIV_STEP);
   assign last_step   = ratio_sum > {1'b0, DIV_MAX};
   assign load_last   = settle_cnt == 16'(LOAD_CYC - 1);
   assign settle_last = ({1'b0, settle_cnt} + 17'd1) >= {1'b0, SETTLE_CYC};
   assign tmo_last    = ({1'b0, tmo_cnt} + 33'd1) >= {1'b0, TIMEOUT_CYC};

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start)                 state_nxt = LOAD;
         LOAD:    if (load_last)             state_nxt = SETTLE;
         SETTLE:  if (settle_last)           state_nxt = START;
         START:                              state_nxt = WAIT;
         WAIT:    if (meas_done || tmo_last) state_nxt = REPORT;
         REPORT:  state_nxt = last_step ? DONE : LOAD;
         DONE:                               state_nxt = IDLE;
         default:                            state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
      end
   end

   // Outputs are registered decodes of the current state, so each lags its state by
   // one cycle; the settle window therefore runs from div_rst_n release to meas_start.
   always_comb begin
      div_rst_n_nxt  = 1'b1;
      meas_start_nxt = 1'b0;
      res_valid_nxt  = 1'b0;
      sweep_done_nxt = 1'b0;
      busy_nxt       = state_nxt != IDLE;
      if (!abort) begin
         case (state)
            LOAD:    div_rst_n_nxt  = 1'b0;
            START:   meas_start_nxt = 1'b1;
            REPORT:  res_valid_nxt  = 1'b1;
            DONE:    sweep_done_nxt = 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_rst_n  <= 1'b1;
         meas_start <= 1'b0;
         res_valid  <= 1'b0;
         sweep_done <= 1'b0;
         busy       <= 1'b0;
      end else begin
         div_rst_n  <= div_rst_n_nxt;
         meas_start <= meas_start_nxt;
         res_valid  <= res_valid_nxt;
         sweep_done <= sweep_done_nxt;
         busy       <= busy_nxt;
      end
   end

   // One counter times both the divider-reset hold and the settle window.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= '0;
      end else if (state_nxt != state) begin
         settle_cnt <= '0;
      end else if (state == LOAD || state == SETTLE) begin
         settle_cnt <= settle_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         tmo_cnt <= '0;
      end else if (state == START) begin
         tmo_cnt <= '0;
      end else if (state == WAIT) begin
         tmo_cnt <= tmo_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         div_n <= DIV_MIN;
      end else if (!abort) begin
         if (state == IDLE && start) begin
            div_n <= DIV_MIN;
         end else if (state == REPORT && !last_step) begin
            div_n <= ratio_sum[DIV_W-1:0];
         end
      end
   end

   // meas_done is checked before the timeout so a same-cycle answer still counts.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         res_div  <= '0;
         res_freq <= '0;
         res_tmo  <= 1'b0;
      end else if (!abort) begin
         if (state == WAIT) begin
            if (meas_done) begin
               res_freq <= meas_freq;
               res_tmo  <= 1'b0;
            end else if (tmo_last) begin
               res_freq <= '0;
               res_tmo  <= 1'b1;
            end
         end
         if (state == REPORT) begin
            res_div <= div_n;
         end
      end
   end

endmodule

// File: tb/tb_clk_sweep_ctrl.sv
// Scoreboard bench: a meter model pushes expected results per measurement and
// monitors compare them whenever the sweep controller reports.
module tb_clk_sweep_ctrl;

   localparam int DMIN   = 2;
   localparam int DMAX   = 6;
   localparam int DSTEP  = 2;
   localparam int SETTLE = 8;
   localparam int TMO    = 50;
   localparam int F_REF  = 50_000_000;
   localparam int B_DIV  = 10;

   typedef struct {
      int div;
      int freq;
      int tmo;
      int lat;
   } exp_t;

   logic        clk_in = 1'b0;
   logic        rst_n  = 1'b0;

   logic        start, abort, meas_done;
   logic [31:0] meas_freq;
   logic [25:0] div_n, res_div;
   logic        div_rst_n, meas_start, res_valid, res_tmo, busy, sweep_done;
   logic [31:0] res_freq;

   logic        start_b, abort_b, meas_done_b;
   logic [31:0] meas_freq_b;
   logic [25:0] div_n_b, res_div_b;
   logic        div_rst_n_b, meas_start_b, res_valid_b, res_tmo_b, busy_b, sweep_done_b;
   logic [31:0] res_freq_b;

   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   exp_t exp_q[$];
   exp_t exp_b[$];
   int   ratio_q[$];
   int   delay_q[$];
   int   done_q[$];
   int   done_b[$];

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   clk_sweep_ctrl #(
      .DIV_MIN(26'd2), .DIV_MAX(26'd6), .DIV_STEP(26'd2),
      .SETTLE_CYC(16'd8), .TIMEOUT_CYC(32'd50)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .start(start), .abort(abort),
      .div_n(div_n), .div_rst_n(div_rst_n), .meas_start(meas_start),
      .meas_done(meas_done), .meas_freq(meas_freq),
      .res_valid(res_valid), .res_div(res_div), .res_freq(res_freq), .res_tmo(res_tmo),
      .busy(busy), .sweep_done(sweep_done)
   );

   clk_sweep_ctrl #(
      .DIV_MIN(26'd10), .DIV_MAX(26'd10), .DIV_STEP(26'd2),
      .SETTLE_CYC(16'd8), .TIMEOUT_CYC(32'd50)
   ) dut_b (
      .clk_in(clk_in), .rst_n(rst_n), .start(start_b), .abort(abort_b),
      .div_n(div_n_b), .div_rst_n(div_rst_n_b), .meas_start(meas_start_b),
      .meas_done(meas_done_b), .meas_freq(meas_freq_b),
      .res_valid(res_valid_b), .res_div(res_div_b), .res_freq(res_freq_b), .res_tmo(res_tmo_b),
      .busy(busy_b), .sweep_done(sweep_done_b)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Meter model for the main DUT: answers after a chosen delay, or stays silent (-1).
   initial begin
      int   r;
      int   d;
      exp_t e;
      meas_done = 1'b0;
      meas_freq = '0;
      forever begin
         @(posedge clk_in); #1;
         meas_done = 1'b0;
         meas_freq = $urandom;
         if (rst_n && meas_start) begin
            if (ratio_q.size() == 0) begin
               chk("meas_start_unexpected", 64'(meas_start), 0);
            end else begin
               r = ratio_q.pop_front();
               chk("div_n_at_meas_start", 64'(div_n), 64'(r));
               d = (delay_q.size() != 0) ? delay_q.pop_front() : int'($urandom_range(0, 58));
               if (d >= 0) begin
                  e.div = r;
                  if (d < TMO) begin
                     e.freq = F_REF / r; e.tmo = 0; e.lat = d + 2;
                  end else begin
                     e.freq = 0; e.tmo = 1; e.lat = TMO + 1;
                  end
                  exp_q.push_back(e);
                  repeat (d) begin
                     @(posedge clk_in); #1;
                     meas_freq = $urandom;
                  end
                  meas_done = 1'b1;
                  meas_freq = 32'(F_REF / r);
               end
            end
         end
      end
   end

   // Monitor for the main DUT.
   initial begin
      int   low_run = 0;
      int   rel_cnt = 0;
      int   last_ms = 0;
      exp_t e;
      forever begin
         @(posedge clk_in); #1;
         if (rst_n) begin
            if (meas_start) begin
               chk("settle_cycles", 64'(rel_cnt), 64'(SETTLE));
               last_ms = cyc;
            end
            if (!div_rst_n) begin
               low_run++;
            end else begin
               if (low_run != 0) chk("div_rst_low_cycles", 64'(low_run), 2);
               low_run = 0;
            end
            rel_cnt = div_rst_n ? rel_cnt + 1 : 0;
            if (res_valid) begin
               if (exp_q.size() == 0) begin
                  chk("res_valid_unexpected", 64'(res_valid), 0);
               end else begin
                  e = exp_q.pop_front();
                  chk("res_div", 64'(res_div), 64'(e.div));
                  chk("res_freq", 64'(res_freq), 64'(e.freq));
                  chk("res_tmo", 64'(res_tmo), 64'(e.tmo));
                  chk("res_latency", 64'(cyc - last_ms), 64'(e.lat));
                  chk("busy_at_result", 64'(busy), 1);
               end
            end
            if (sweep_done) begin
               if (done_q.size() == 0) begin
                  chk("sweep_done_unexpected", 64'(sweep_done), 0);
               end else begin
                  void'(done_q.pop_front());
                  chk("busy_at_sweep_done", 64'(busy), 0);
                  chk("results_before_done", 64'(exp_q.size()), 0);
               end
            end
         end
      end
   end

   // Meter model and monitor for the single-ratio DUT.
   initial begin
      meas_done_b = 1'b0;
      meas_freq_b = '0;
      forever begin
         @(posedge clk_in); #1;
         meas_done_b = 1'b0;
         if (rst_n && meas_start_b) begin
            repeat (4) @(posedge clk_in);
            #1;
            meas_done_b = 1'b1;
            meas_freq_b = 32'(F_REF / B_DIV);
         end
      end
   end

   initial begin
      int   last_rv = 0;
      exp_t e;
      forever begin
         @(posedge clk_in); #1;
         if (rst_n && res_valid_b) begin
            last_rv = cyc;
            if (exp_b.size() == 0) begin
               chk("b_res_valid_unexpected", 64'(res_valid_b), 0);
            end else begin
               e = exp_b.pop_front();
               chk("b_res_div", 64'(res_div_b), 64'(e.div));
               chk("b_res_freq", 64'(res_freq_b), 64'(e.freq));
               chk("b_res_tmo", 64'(res_tmo_b), 64'(e.tmo));
            end
         end
         if (rst_n && sweep_done_b) begin
            if (done_b.size() == 0) begin
               chk("b_sweep_done_unexpected", 64'(sweep_done_b), 0);
            end else begin
               void'(done_b.pop_front());
               chk("b_done_after_result", 64'(cyc - last_rv), 1);
               chk("b_busy_at_done", 64'(busy_b), 0);
            end
         end
      end
   end

   task automatic begin_sweep(input bit expect_done, output int s);
      for (int r = DMIN; r <= DMAX; r += DSTEP) ratio_q.push_back(r);
      if (expect_done) done_q.push_back(1);
      start = 1'b1;
      s = cyc;
      @(posedge clk_in); #1;
      start = 1'b0;
   endtask

   task automatic wait_meas_start(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge clk_in); #1;
         seen = meas_start;
      end
      chk("meas_start_within_budget", 64'(seen), 1);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || busy_b) && n < budget) begin
         @(posedge clk_in); #1;
         n++;
      end
      chk("sweep_ends_within_budget", 64'(busy | busy_b), 0);
      repeat (10) @(posedge clk_in);
      #1;
   endtask

   initial begin
      int   s;
      bit   seen;
      exp_t e;
      start = 1'b0; abort = 1'b0; start_b = 1'b0; abort_b = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      chk("rst_div_n", 64'(div_n), 64'(DMIN));
      chk("rst_div_rst_n", 64'(div_rst_n), 1);
      chk("rst_meas_start", 64'(meas_start), 0);
      chk("rst_res_valid", 64'(res_valid), 0);
      chk("rst_res_freq", 64'(res_freq), 0);
      chk("rst_busy", 64'(busy), 0);
      chk("rst_sweep_done", 64'(sweep_done), 0);
      chk("rst_b_div_n", 64'(div_n_b), 64'(B_DIV));
      rst_n = 1'b1;
      @(posedge clk_in); #1;

      // DIV_MIN == DIV_MAX: one result then sweep_done.
      e.div = B_DIV; e.freq = F_REF / B_DIV; e.tmo = 0; e.lat = 0;
      exp_b.push_back(e);
      done_b.push_back(1);
      start_b = 1'b1;
      @(posedge clk_in); #1;
      start_b = 1'b0;
      wait_idle(400);

      // Basic sweep with start-to-measurement latency.
      delay_q = '{3, 10, 20};
      begin_sweep(1, s);
      chk("busy_after_start", 64'(busy), 1);
      wait_meas_start(100, seen);
      chk("start_to_meas_start", 64'(cyc - s), 12);
      wait_idle(400);

      // Timeout, answer on the expiry cycle, and answers that arrive too late.
      delay_q = '{55, 49, 50};
      begin_sweep(1, s);
      wait_idle(400);

      // Start while busy is ignored.
      begin_sweep(1, s);
      repeat (4) @(posedge clk_in);
      #1;
      start = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0;
      chk("busy_ignores_start", 64'(busy), 1);
      wait_idle(400);

      repeat (6) begin
         begin_sweep(1, s);
         wait_idle(400);
      end

      // Abort during the wait of the second step.
      delay_q = '{5, -1};
      begin_sweep(0, s);
      wait_meas_start(200, seen);
      wait_meas_start(200, seen);
      repeat (10) @(posedge clk_in);
      #1;
      abort = 1'b1;
      @(posedge clk_in); #1;
      abort = 1'b0;
      chk("abort_busy", 64'(busy), 0);
      chk("abort_div_rst_n", 64'(div_rst_n), 1);
      repeat (150) @(posedge clk_in);
      #1;
      ratio_q.delete();
      begin_sweep(1, s);
      wait_idle(400);

      // Abort beats start in the same cycle.
      start = 1'b1; abort = 1'b1;
      @(posedge clk_in); #1;
      start = 1'b0; abort = 1'b0;
      chk("abort_beats_start_busy", 64'(busy), 0);
      repeat (20) @(posedge clk_in);
      #1;
      chk("abort_beats_start_idle", 64'(busy), 0);

      // Asynchronous reset while settling the third ratio.
      delay_q = '{2, 2};
      begin_sweep(0, s);
      for (int i = 0; i < 400 && !(div_n == 26'(DMAX) && div_rst_n); i++) begin
         @(posedge clk_in); #1;
      end
      chk("reached_last_ratio", 64'(div_n), 64'(DMAX));
      repeat (3) @(posedge clk_in);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_div_n", 64'(div_n), 64'(DMIN));
      chk("midrst_div_rst_n", 64'(div_rst_n), 1);
      chk("midrst_busy", 64'(busy), 0);
      chk("midrst_res_div", 64'(res_div), 0);
      chk("midrst_res_freq", 64'(res_freq), 0);
      chk("midrst_meas_start", 64'(meas_start), 0);
      ratio_q.delete();
      delay_q.delete();
      @(posedge clk_in); #1;
      rst_n = 1'b1;
      @(posedge clk_in); #1;
      begin_sweep(1, s);
      wait_idle(400);

      chk("results_outstanding", 64'(exp_q.size()), 0);
      chk("sweeps_outstanding", 64'(done_q.size()), 0);
      chk("b_outstanding", 64'(exp_b.size() + done_b.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
